// File: rtl/fir_channel_scheduler_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
// Channel indices and coefficient addresses are sized through idx_w().
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        LOAD
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching from an internal pointer.
// The pointer advances past the winner only on cycles where grant_en is high.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             grant_en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        any       = |req;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IDX_W'((32'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_en && any) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one serial-MAC FIR core across NUM_CH sample channels (one-deep buffer per
// channel, round-robin grant) and sequences drain + coefficient reload into the core.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RES_W  = 36,
    parameter int unsigned TAPS   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       core_start,
    output logic [idx_w(NUM_CH)-1:0]   core_ch,
    output logic [DATA_W-1:0]          core_data,
    input  logic                       core_done,
    input  logic [RES_W-1:0]           core_result,
    output logic                       out_valid,
    output logic [idx_w(NUM_CH)-1:0]   out_ch,
    output logic [RES_W-1:0]           out_data,
    input  logic                       cfg_req,
    input  logic                       cfg_valid,
    input  logic [DATA_W-1:0]          cfg_data,
    output logic                       cfg_ready,
    output logic                       coeff_we,
    output logic [idx_w(TAPS)-1:0]     coeff_addr,
    output logic [DATA_W-1:0]          coeff_data,
    output logic                       cfg_done
);

    localparam int unsigned CH_W = idx_w(NUM_CH);
    localparam int unsigned AW   = idx_w(TAPS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] full;
    logic [DATA_W-1:0] buf_data [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_full;
    logic [CH_W-1:0]   job_ch;
    logic [DATA_W-1:0] job_data;
    logic [AW-1:0]     cnt;
    logic              last_word;
    logic              job_done;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (full),
        .grant_en  (core_start),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_full)
    );

    assign in_ready = ~full;

    // The job fields are presented combinationally in the grant cycle, then held from registers.
    assign core_ch    = core_start ? grant_idx : job_ch;
    assign core_data  = core_start ? buf_data[grant_idx] : job_data;
    assign coeff_addr = cnt;
    assign coeff_data = cfg_data;

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        cfg_ready  = 1'b0;
        coeff_we   = 1'b0;
        last_word  = 1'b0;
        job_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_req) begin
                    state_nxt = LOAD;
                end else if (any_full) begin
                    core_start = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (core_done) begin
                    job_done  = 1'b1;
                    state_nxt = cfg_req ? DRAIN : IDLE;
                end
            end
            DRAIN: state_nxt = LOAD;
            LOAD: begin
                cfg_ready = 1'b1;
                coeff_we  = cfg_valid;
                last_word = cfg_valid && (cnt == LAST_ADDR);
                if (last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                full[i] <= 1'b0;
            end else if (core_start && grant[i]) begin
                full[i] <= 1'b0;
            end else if (in_valid[i] && !full[i]) begin
                full[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && !full[i]) begin
                buf_data[i] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_ch    <= '0;
            job_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            cfg_done  <= 1'b0;
            cnt       <= '0;
        end else begin
            if (core_start) begin
                job_ch   <= grant_idx;
                job_data <= buf_data[grant_idx];
            end
            out_valid <= job_done;
            if (job_done) begin
                out_ch   <= job_ch;
                out_data <= core_result;
            end
            cfg_done <= last_word;
            if (coeff_we) begin
                cnt <= last_word ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: expected grants are queued with the stimulus,
// a core model answers each start and queues the expected result for the output check.
module tb_fir_channel_scheduler;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] d;
    } job_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [35:0] res;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_ready;
    logic        core_start;
    logic [1:0]  core_ch;
    logic [15:0] core_data;
    logic        core_done = 1'b0;
    logic [35:0] core_result = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [35:0] out_data;
    logic        cfg_req = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ready;
    logic        coeff_we;
    logic [3:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        cfg_done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    job_t exp_grant[$];
    res_t exp_out[$];

    int unsigned done_delay  = 3;
    int unsigned busy_cnt    = 0;
    int unsigned cfg_done_cnt = 0;
    int unsigned block_level = 0;
    int unsigned exp_addr    = 0;
    logic        chk_ready   = 1'b0;
    logic        stray_req   = 1'b0;
    logic [1:0]  cur_ch      = '0;
    logic [35:0] cur_res     = '0;

    fir_channel_scheduler #(
        .NUM_CH (4),
        .DATA_W (16),
        .RES_W  (36),
        .TAPS   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .core_start  (core_start),
        .core_ch     (core_ch),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .cfg_req     (cfg_req),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_data  (coeff_data),
        .cfg_done    (cfg_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [35:0] res_fn(input logic [1:0] ch, input logic [15:0] d);
        return {2'b00, ch, ~d, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        cfg_req = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input logic [15:0] d);
        check($sformatf("in_ready_ch%0d", ch), 64'(in_ready[ch]), 1);
        in_valid[ch] = 1'b1;
        in_data[ch*16 +: 16] = d;
        tick();
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_grant.size() != 0 || exp_out.size() != 0 || busy_cnt != 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(tag, 64'(exp_grant.size() + exp_out.size() + busy_cnt), 0);
    endtask

    task automatic load_coeffs(input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_ready%0d", tag, k), 64'(cfg_ready), 1);
            cfg_valid = 1'b1;
            cfg_data  = 16'hC000 | 16'(k);
            tick();
            cfg_valid = 1'b0;
            if (k % 3 == 1) tick();
        end
        check({tag, "_cfg_done"}, 64'(cfg_done), 1);
        check({tag, "_ready_off"}, 64'(cfg_ready), 0);
    endtask

    // Core model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        job_t j;
        res_t r;
        if (rst) begin
            busy_cnt  = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (cfg_done) cfg_done_cnt++;
            if (out_valid) begin
                check("out_pending", 64'(exp_out.size()), 1);
                if (exp_out.size() != 0) begin
                    r = exp_out.pop_front();
                    check("out_ch_data", {26'b0, out_ch, out_data}, {26'b0, r.ch, r.res});
                end
            end
            if (coeff_we) begin
                check("coeff_addr", 64'(coeff_addr), 64'(exp_addr));
                check("coeff_data", 64'(coeff_data), 64'(16'hC000 | 16'(exp_addr)));
                exp_addr = (exp_addr + 1) % 16;
            end
            if (stray_req) begin
                core_done   = 1'b1;
                core_result = 36'hDEAD;
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    core_done   = 1'b1;
                    core_result = cur_res;
                    exp_out.push_back('{ch: cur_ch, res: cur_res});
                end
            end
            if (core_start) begin
                check("grant_pending", 64'(exp_grant.size() != 0), 1);
                check("grant_after_cfg", 64'(cfg_done_cnt >= block_level), 1);
                if (exp_grant.size() != 0) begin
                    j = exp_grant.pop_front();
                    check("grant_ch_data", {46'b0, core_ch, core_data}, {46'b0, j.ch, j.d});
                    if (chk_ready) check("ready_at_grant", 64'(in_ready), 64'((4'b1 << j.ch) - 4'b1));
                    cur_ch   = j.ch;
                    cur_res  = res_fn(j.ch, j.d);
                    busy_cnt = done_delay;
                end
            end
        end
    end

    initial begin : stim
        int unsigned n0, n3, guard;
        logic [3:0] r;

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_outputs", {58'b0, out_valid, core_start, cfg_ready, cfg_done, coeff_we, 1'b0}, 0);
        check("rst_fields", {8'b0, core_ch, core_data, out_ch, out_data}, 0);
        rst = 1'b0;

        // 1: single sample on ch2, start one cycle after acceptance
        done_delay = 3;
        exp_grant.push_back('{ch: 2'd2, d: 16'h1234});
        send(2, 16'h1234);
        check("t1_start", 64'(core_start), 1);
        check("t1_ch_data", {46'b0, core_ch, core_data}, {46'b0, 2'd2, 16'h1234});
        check("t1_in_ready", 64'(in_ready), 64'hB);
        wait_idle("t1_drain", 50);

        // 2: all channels at once, grants 0..3 in order
        do_reset();
        done_delay = 5;
        chk_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back('{ch: 2'(i), d: 16'h2000 + 16'(i)});
            in_valid[i] = 1'b1;
            in_data[i*16 +: 16] = 16'h2000 + 16'(i);
        end
        tick();
        in_valid = '0;
        check("t2_all_full", 64'(in_ready), 0);
        wait_idle("t2_drain", 100);
        chk_ready = 1'b0;

        // 3: reload requested mid-job; ch1 held until the reload completes
        done_delay = 6;
        exp_grant.push_back('{ch: 2'd0, d: 16'h3000});
        send(0, 16'h3000);
        tick();
        cfg_req = 1'b1;
        block_level = cfg_done_cnt + 1;
        exp_grant.push_back('{ch: 2'd1, d: 16'h3001});
        send(1, 16'h3001);
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("t3_out_seen", 64'(out_valid), 1);
        check("t3_drain_not_ready", 64'(cfg_ready), 0);
        tick();
        check("t3_load_ready", 64'(cfg_ready), 1);
        cfg_req = 1'b0;
        load_coeffs("t3");
        wait_idle("t3_drain", 50);
        check("t3_cfg_done_cnt", 64'(cfg_done_cnt), 1);

        // 4: reload and a pending sample together in IDLE; reload wins
        exp_grant.push_back('{ch: 2'd1, d: 16'h4001});
        block_level = cfg_done_cnt + 1;
        cfg_req = 1'b1;
        in_valid[1] = 1'b1;
        in_data[16 +: 16] = 16'h4001;
        tick();
        in_valid = '0;
        check("t4_load_first", 64'(cfg_ready), 1);
        check("t4_no_start", 64'(core_start), 0);
        cfg_req = 1'b0;
        load_coeffs("t4");
        wait_idle("t4_drain", 50);
        check("t4_cfg_done_cnt", 64'(cfg_done_cnt), 2);

        // 5: reset during a job, then a stray core_done
        done_delay = 40;
        exp_grant.push_back('{ch: 2'd1, d: 16'h5001});
        send(1, 16'h5001);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_no_out", 64'(out_valid), 0);
            tick();
        end
        check("t5_in_ready", 64'(in_ready), 64'hF);
        done_delay = 3;
        exp_grant.push_back('{ch: 2'd0, d: 16'h5100});
        exp_grant.push_back('{ch: 2'd2, d: 16'h5102});
        in_valid = 4'b0101;
        in_data[0 +: 16]  = 16'h5100;
        in_data[32 +: 16] = 16'h5102;
        tick();
        in_valid = '0;
        wait_idle("t5_drain", 50);

        // 6: continuous traffic on ch0 and ch3 alternates
        do_reset();
        done_delay = 2;
        for (int k = 0; k < 8; k++) begin
            exp_grant.push_back('{ch: 2'd0, d: 16'h0A00 + 16'(k)});
            exp_grant.push_back('{ch: 2'd3, d: 16'h0D00 + 16'(k)});
        end
        n0 = 0;
        n3 = 0;
        in_valid = 4'b1001;
        in_data[0 +: 16]  = 16'h0A00;
        in_data[48 +: 16] = 16'h0D00;
        guard = 0;
        while ((n0 < 8 || n3 < 8) && guard < 400) begin
            @(negedge clk);
            r = in_ready;
            tick();
            if (in_valid[0] && r[0]) n0++;
            if (in_valid[3] && r[3]) n3++;
            in_valid[0] = (n0 < 8);
            in_valid[3] = (n3 < 8);
            in_data[0 +: 16]  = 16'h0A00 + 16'(n0);
            in_data[48 +: 16] = 16'h0D00 + 16'(n3);
            guard++;
        end
        in_valid = '0;
        check("t6_accepts", 64'(n0 + n3), 16);
        wait_idle("t6_drain", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
